// File: rtl/bayer_mosaic.sv
// bayer_mosaic
//   Converts an RGB888 pixel stream into an 8-bit Bayer raw stream. Each raw
//   sample also carries its linear frame address. The Bayer phase matches the
//   demosaic cX/cY convention, so a mosaic->demosaic round trip stays
//   pixel-aligned:
//     (odd,odd)=G, (odd,even)=B, (even,odd)=R, (even,even)=G   as (cX,cY)
//
//   Optional build macro: MOSAIC_TESTPAT_EN
//     Adds input test_mode. While test_mode=1, the RGB inputs are replaced by
//     8 vertical colour bars, each size_x/8 wide, in this order: white,
//     yellow, cyan, green, magenta, red, blue, black.
//
// Parameters
//   size_x       active pixels per line
//   size_y       active lines per frame
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   in_valid     RGB pixel present on red/green/blue
//   in_ready     block can accept a pixel this cycle (combinational)
//   sof          start-of-frame; forces the accepted pixel to (0,0)
//   red/green/blue  input pixel
//   test_mode    (MOSAIC_TESTPAT_EN only) select colour-bar source
//   out_valid    raw/address_out hold a valid sample
//   out_ready    downstream accepts the sample
//   raw          Bayer sample
//   address_out  cY*size_x+cX of the raw sample
//   frame_done   high with the beat of the last pixel of the frame
module bayer_mosaic #(
  parameter int size_x = 640,
  parameter int size_y = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sof,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
`ifdef MOSAIC_TESTPAT_EN
  input  logic        test_mode,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  raw,
  output logic [18:0] address_out,
  output logic        frame_done
);

  localparam int CX_W   = (size_x > 1) ? $clog2(size_x) : 1;
  localparam int CY_W   = (size_y > 1) ? $clog2(size_y) : 1;
  localparam int ADDR_W = 19;
  localparam logic [CX_W-1:0] X_LAST = CX_W'(size_x - 1);
  localparam logic [CY_W-1:0] Y_LAST = CY_W'(size_y - 1);

  function automatic logic [7:0] bayer_pick(input logic x_odd, input logic y_odd,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
    logic [7:0] s;
    case ({x_odd, y_odd})
      2'b11:   s = g;
      2'b10:   s = b;
      2'b01:   s = r;
      default: s = g;
    endcase
    return s;
  endfunction

`ifdef MOSAIC_TESTPAT_EN
  localparam int unsigned BAR_W = (size_x / 8 > 0) ? size_x / 8 : 1;

  // Returns {R,G,B} on/off flags for one colour bar.
  function automatic logic [2:0] bar_colour(input logic [2:0] bar);
    logic [2:0] c;
    case (bar)
      3'd0:    c = 3'b111;  // white
      3'd1:    c = 3'b110;  // yellow
      3'd2:    c = 3'b011;  // cyan
      3'd3:    c = 3'b010;  // green
      3'd4:    c = 3'b101;  // magenta
      3'd5:    c = 3'b100;  // red
      3'd6:    c = 3'b001;  // blue
      default: c = 3'b000;  // black
    endcase
    return c;
  endfunction

  int unsigned bar_i;
  logic [2:0]  bar_idx;
  logic [2:0]  bar_rgb;
`endif

  logic [CX_W-1:0]   cnt_x;
  logic [CY_W-1:0]   cnt_y;
  logic [ADDR_W-1:0] addr_cnt;

  logic              accept;
  logic [CX_W-1:0]   eff_x;
  logic [CY_W-1:0]   eff_y;
  logic [ADDR_W-1:0] eff_addr;
  logic              last_px;
  logic [7:0]        pix_r, pix_g, pix_b;
  logic [7:0]        sample;

  assign in_ready = !out_valid | out_ready;

  // Input stage: sof overrides the running position so that the accepted
  // pixel lands on (0,0) and counting resumes from there.
  always_comb begin
    accept   = in_valid & in_ready;
    eff_x    = sof ? '0 : cnt_x;
    eff_y    = sof ? '0 : cnt_y;
    eff_addr = sof ? '0 : addr_cnt;
    last_px  = (eff_x == X_LAST) && (eff_y == Y_LAST);
    pix_r    = red;
    pix_g    = green;
    pix_b    = blue;
`ifdef MOSAIC_TESTPAT_EN
    bar_i    = 32'(eff_x) / BAR_W;
    bar_idx  = (bar_i > 7) ? 3'd7 : 3'(bar_i);
    bar_rgb  = bar_colour(bar_idx);
    if (test_mode) begin
      pix_r = {8{bar_rgb[2]}};
      pix_g = {8{bar_rgb[1]}};
      pix_b = {8{bar_rgb[0]}};
    end
`endif
    sample   = bayer_pick(eff_x[0], eff_y[0], pix_r, pix_g, pix_b);
  end

  // Position counters; the address runs in step with them, so a plain +1
  // covers the line wrap and no multiplier is needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_x    <= '0;
      cnt_y    <= '0;
      addr_cnt <= '0;
    end else if (accept) begin
      if (last_px) begin
        cnt_x    <= '0;
        cnt_y    <= '0;
        addr_cnt <= '0;
      end else if (eff_x == X_LAST) begin
        cnt_x    <= '0;
        cnt_y    <= eff_y + CY_W'(1);
        addr_cnt <= eff_addr + ADDR_W'(1);
      end else begin
        cnt_x    <= eff_x + CX_W'(1);
        cnt_y    <= eff_y;
        addr_cnt <= eff_addr + ADDR_W'(1);
      end
    end
  end

  // Output stage: a single register. When stalled, in_ready is low, so no
  // accept can happen and the held values stay put.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      raw         <= '0;
      address_out <= '0;
      frame_done  <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      raw         <= sample;
      address_out <= eff_addr;
      frame_done  <= last_px;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bayer_mosaic.sv
// Testbench for bayer_mosaic (size_x=4, size_y=2), with a reference model
// that works from the linear pixel index of each accepted pixel.
module tb_bayer_mosaic;

  localparam int SX = 4;
  localparam int SY = 2;

  typedef struct packed {
    logic [7:0]  raw;
    logic [18:0] addr;
    logic        fd;
  } exp_t;

  typedef struct packed {
    logic        beat;
    logic        vld;
    logic        ordy;
    logic        in_rdy;
    logic [7:0]  raw;
    logic [18:0] addr;
    logic        fd;
    logic        has_exp;
    logic [7:0]  e_raw;
    logic [18:0] e_addr;
    logic        e_fd;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        sof;
  logic [7:0]  red, green, blue;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  raw;
  logic [18:0] address_out;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int mk = 0;
  exp_t q[$];

  always #5 clock = ~clock;

  bayer_mosaic #(.size_x(SX), .size_y(SY)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sof(sof), .red(red), .green(green), .blue(blue),
`ifdef MOSAIC_TESTPAT_EN
    .test_mode(1'b0),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .raw(raw),
    .address_out(address_out), .frame_done(frame_done)
  );

  function automatic logic [7:0] pick(input int x, input int y,
                                      input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    if ((x % 2 == 1) && (y % 2 == 1)) return g;
    if (x % 2 == 1) return b;
    if (y % 2 == 1) return r;
    return g;
  endfunction

  // One clock: drive inputs, observe at the falling edge, update the model.
  task automatic run_cycle(input logic iv, input logic s, input logic [7:0] r,
                           input logic [7:0] g, input logic [7:0] b,
                           input logic ordy, output obs_t o);
    exp_t e;
    int x, y;
    logic last;
    in_valid  = iv;
    sof       = s;
    red       = r;
    green     = g;
    blue      = b;
    out_ready = ordy;
    @(negedge clock);
    o        = '0;
    o.vld    = out_valid;
    o.ordy   = ordy;
    o.in_rdy = in_ready;
    o.raw    = raw;
    o.addr   = address_out;
    o.fd     = frame_done;
    o.beat   = out_valid & ordy;
    if (o.beat && q.size() > 0) begin
      e         = q.pop_front();
      o.has_exp = 1'b1;
      o.e_raw   = e.raw;
      o.e_addr  = e.addr;
      o.e_fd    = e.fd;
    end
    if (iv && in_ready) begin
      if (s) mk = 0;
      x    = mk % SX;
      y    = mk / SX;
      last = (mk == SX * SY - 1);
      q.push_back('{pick(x, y, r, g, b), 19'(mk), last});
      mk   = last ? 0 : mk + 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; sof = 1'b0; out_ready = 1'b0;
    red = '0; green = '0; blue = '0;
    repeat (2) @(posedge clock);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (raw !== 8'h00) begin fails++; $display("FAIL reset_raw got %h want 00", raw); end
    tests++; if (address_out !== 19'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", address_out); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    reset = 1'b0;
    q.delete();
    mk = 0;
  endtask

  task automatic test_stream();
    logic [7:0] tbl [8];
    obs_t o;
    int beats = 0;
    tbl = '{8'h20, 8'h30, 8'h20, 8'h30, 8'h10, 8'h20, 8'h10, 8'h20};
    for (int c = 0; c < 20 && beats < 8; c++) begin
      run_cycle(c < 8, 1'b0, 8'h10, 8'h20, 8'h30, 1'b1, o);
      if (o.beat) begin
        tests++; if (o.raw !== tbl[beats]) begin fails++; $display("FAIL stream_raw beat %0d got %h want %h", beats, o.raw, tbl[beats]); end
        tests++; if (o.addr !== 19'(beats)) begin fails++; $display("FAIL stream_addr beat %0d got %0d want %0d", beats, o.addr, beats); end
        tests++; if (o.fd !== (beats == 7)) begin fails++; $display("FAIL stream_frame_done beat %0d got %b want %b", beats, o.fd, beats == 7); end
        beats++;
      end
    end
    tests++; if (beats != 8) begin fails++; $display("FAIL stream_beats got %0d want 8", beats); end
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, o);
  endtask

  task automatic test_backpressure();
    obs_t o, snap;
    int beats = 0;
    int sent = 0;
    run_cycle(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, o);
    sent = 1;
    for (int c = 0; c < 3; c++) begin
      run_cycle(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, o);
      if (c == 0) snap = o;
      tests++; if (o.in_rdy !== 1'b0) begin fails++; $display("FAIL hold_in_ready cycle %0d got %b want 0", c, o.in_rdy); end
      tests++; if (o.vld !== 1'b1 || o.raw !== snap.raw || o.addr !== snap.addr) begin
        fails++; $display("FAIL hold_stable cycle %0d got v=%b %h/%0d want v=1 %h/%0d", c, o.vld, o.raw, o.addr, snap.raw, snap.addr);
      end
    end
    for (int c = 0; c < 20 && beats < 5; c++) begin
      run_cycle(sent < 5, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, o);
      if (sent < 5 && o.in_rdy) sent++;
      if (o.beat) begin
        beats++;
        tests++; if (!o.has_exp || o.raw !== o.e_raw || o.addr !== o.e_addr || o.fd !== o.e_fd) begin
          fails++; $display("FAIL release_beat got %h/%0d/%b want %h/%0d/%b (exp=%b)", o.raw, o.addr, o.fd, o.e_raw, o.e_addr, o.e_fd, o.has_exp);
        end
      end
    end
    tests++; if (beats != 5 || q.size() != 0) begin fails++; $display("FAIL release_count got %0d beats, %0d pending want 5, 0", beats, q.size()); end
  endtask

  task automatic test_sof();
    obs_t o;
    int beats = 0;
    for (int c = 0; c < 20 && beats < 8; c++) begin
      run_cycle(c < 8, c == 4, 8'h10, 8'h20, 8'h30, 1'b1, o);
      if (o.beat) begin
        tests++; if (!o.has_exp || o.raw !== o.e_raw || o.addr !== o.e_addr || o.fd !== o.e_fd) begin
          fails++; $display("FAIL sof_beat %0d got %h/%0d/%b want %h/%0d/%b", beats, o.raw, o.addr, o.fd, o.e_raw, o.e_addr, o.e_fd);
        end
        if (beats == 4) begin
          tests++; if (o.raw !== 8'h20 || o.addr !== 19'd0) begin fails++; $display("FAIL sof_pixel got %h/%0d want 20/0", o.raw, o.addr); end
        end
        if (beats == 5) begin
          tests++; if (o.raw !== 8'h30 || o.addr !== 19'd1) begin fails++; $display("FAIL sof_next got %h/%0d want 30/1", o.raw, o.addr); end
        end
        beats++;
      end
    end
    tests++; if (beats != 8) begin fails++; $display("FAIL sof_beats got %0d want 8", beats); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    for (int c = 0; c < 5; c++) begin
      run_cycle(1'b1, c == 0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, o);
      if (o.beat) begin
        tests++; if (!o.has_exp || o.raw !== o.e_raw || o.addr !== o.e_addr) begin
          fails++; $display("FAIL midrst_lead got %h/%0d want %h/%0d", o.raw, o.addr, o.e_raw, o.e_addr);
        end
      end
    end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_pending got %b want 1", out_valid); end
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clock);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    reset = 1'b0;
    q.delete();
    mk = 0;
    run_cycle(1'b1, 1'b0, 8'h11, 8'h22, 8'h33, 1'b1, o);
    run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, o);
    tests++; if (!o.beat || o.addr !== 19'd0 || o.raw !== 8'h22) begin
      fails++; $display("FAIL midrst_first got beat=%b %h/%0d want beat=1 22/0", o.beat, o.raw, o.addr);
    end
  endtask

  task automatic test_random();
    obs_t o, prev;
    prev = '0;
    for (int c = 0; c < 400; c++) begin
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 9) < 7, o);
      if (prev.vld && !prev.ordy) begin
        tests++; if (o.vld !== 1'b1 || o.raw !== prev.raw || o.addr !== prev.addr || o.fd !== prev.fd) begin
          fails++; $display("FAIL rand_hold cycle %0d got %b %h/%0d/%b want 1 %h/%0d/%b", c, o.vld, o.raw, o.addr, o.fd, prev.raw, prev.addr, prev.fd);
        end
      end
      if (o.beat) begin
        tests++; if (!o.has_exp || o.raw !== o.e_raw || o.addr !== o.e_addr || o.fd !== o.e_fd) begin
          fails++; $display("FAIL rand_beat cycle %0d got %h/%0d/%b want %h/%0d/%b (exp=%b)", c, o.raw, o.addr, o.fd, o.e_raw, o.e_addr, o.e_fd, o.has_exp);
        end
      end
      prev = o;
    end
    for (int c = 0; c < 4; c++) begin
      run_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, o);
      if (o.beat) begin
        tests++; if (!o.has_exp || o.raw !== o.e_raw || o.addr !== o.e_addr || o.fd !== o.e_fd) begin
          fails++; $display("FAIL rand_drain got %h/%0d/%b want %h/%0d/%b", o.raw, o.addr, o.fd, o.e_raw, o.e_addr, o.e_fd);
        end
      end
    end
    tests++; if (q.size() != 0) begin fails++; $display("FAIL rand_lost got %0d pending want 0", q.size()); end
  endtask

`ifdef MOSAIC_TESTPAT_EN
  localparam int TSX = 16;
  logic        tp_in_ready, tp_out_valid, tp_frame_done;
  logic [7:0]  tp_raw;
  logic [18:0] tp_addr;
  logic        tp_in_valid = 1'b0;

  bayer_mosaic #(.size_x(TSX), .size_y(2)) tp_dut (
    .clock(clock), .reset(reset), .in_valid(tp_in_valid), .in_ready(tp_in_ready),
    .sof(1'b0), .red(red), .green(green), .blue(blue), .test_mode(1'b1),
    .out_valid(tp_out_valid), .out_ready(1'b1), .raw(tp_raw),
    .address_out(tp_addr), .frame_done(tp_frame_done)
  );

  function automatic logic [7:0] bar_sample(input int x, input int y);
    logic [2:0] tbl [8];
    logic [2:0] c;
    tbl = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    c = tbl[x / (TSX / 8)];
    return pick(x, y, {8{c[2]}}, {8{c[1]}}, {8{c[0]}});
  endfunction

  task automatic test_testpat();
    logic [7:0] seen [32];
    int beats = 0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 40 && beats < 32; c++) begin
      tp_in_valid = (c < 32);
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
      @(negedge clock);
      if (tp_out_valid) begin
        seen[tp_addr[4:0]] = tp_raw;
        beats++;
      end
      @(posedge clock); #1;
    end
    tp_in_valid = 1'b0;
    tests++; if (beats != 32) begin fails++; $display("FAIL tp_beats got %0d want 32", beats); end
    tests++; if (seen[0] !== 8'hFF) begin fails++; $display("FAIL tp_white got %h want ff", seen[0]); end
    tests++; if (seen[30] !== 8'h00) begin fails++; $display("FAIL tp_black got %h want 00", seen[30]); end
    for (int a = 0; a < 32; a++) begin
      tests++; if (seen[a] !== bar_sample(a % TSX, a / TSX)) begin
        fails++; $display("FAIL tp_bar addr %0d got %h want %h", a, seen[a], bar_sample(a % TSX, a / TSX));
      end
    end
    q.delete();
    mk = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_sof();
    test_reset_mid();
    test_random();
`ifdef MOSAIC_TESTPAT_EN
    test_testpat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
